// File: rtl/mix_controller_if.sv
// mix_controller_if: handshake and data between the mix controller and the channel mixer.
//   mix_start_out : controller -> mixer, one-cycle launch pulse (mixer valid_in)
//   shift_out     : controller -> mixer, output scaling shift
//   mix_done_in   : mixer -> controller, completion strobe (mixer valid_out)
//   mixed_in      : mixer -> controller, signed mixed sample
interface mix_controller_if;
    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned SHIFT_W  = 5;

    logic                       mix_start_out;
    logic [SHIFT_W-1:0]         shift_out;
    logic                       mix_done_in;
    logic signed [SAMPLE_W-1:0] mixed_in;

    modport master (
        output mix_start_out,
        output shift_out,
        input  mix_done_in,
        input  mixed_in
    );

    modport slave (
        input  mix_start_out,
        input  shift_out,
        output mix_done_in,
        output mixed_in
    );
endinterface

// File: rtl/mix_controller.sv
// mix_controller: launches one mixer operation per audio sample, waits for completion,
// registers the result and drives the mixer shift, optionally under automatic gain control.
// Ports:
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   sample_valid_in      : one-cycle strobe, new sample ready for mixing
//   agc_en_in            : 1 = AGC owns shift, 0 = shift_manual_in is used
//   shift_manual_in      : manual shift, latched when a sample is accepted with AGC off
//   overrun_clr_in       : clears the sticky overrun/timeout flags
//   mix_bus (master)     : mix_start_out / shift_out to mixer, mix_done_in / mixed_in from mixer
//   audio_out            : last completed mixed sample
//   audio_valid_out      : one-cycle pulse when audio_out updates
//   busy_out             : high whenever the sequencer is not idle
//   overrun_out          : sticky, a sample strobe arrived while busy
//   timeout_out          : sticky, the mixer failed to complete in time
module mix_controller #(
    parameter logic [4:0]  INIT_SHIFT  = 5'd8,
    parameter logic [23:0] CLIP_LIMIT  = 24'h700000,
    parameter logic [23:0] QUIET_LIMIT = 24'h040000,
    parameter int unsigned QUIET_HOLD  = 4800,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                sample_valid_in,
    input  logic                agc_en_in,
    input  logic [4:0]          shift_manual_in,
    input  logic                overrun_clr_in,
    mix_controller_if.master    mix_bus,
    output logic signed [23:0]  audio_out,
    output logic                audio_valid_out,
    output logic                busy_out,
    output logic                overrun_out,
    output logic                timeout_out
);
    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned SHIFT_W  = 5;
    localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned QC_W     = $clog2(QUIET_HOLD + 1);

    localparam logic [SHIFT_W-1:0] SHIFT_MAX = '1;
    localparam logic [SHIFT_W-1:0] SHIFT_MIN = '0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ADJUST = 2'd3;

    logic [1:0]          state_q,       state_d;
    logic [TO_W-1:0]     to_cnt_q,      to_cnt_d;
    logic [QC_W-1:0]     quiet_q,       quiet_d;
    logic [SAMPLE_W-1:0] sample_q,      sample_d;
    logic [SAMPLE_W-1:0] audio_q,       audio_d;
    logic                audio_valid_q, audio_valid_d;
    logic                mix_start_q,   mix_start_d;
    logic [SHIFT_W-1:0]  shift_q,       shift_d;
    logic                busy_q,        busy_d;
    logic                overrun_q,     overrun_d;
    logic                timeout_q,     timeout_d;
    logic [SAMPLE_W-1:0] mag;

    // Magnitude of the captured sample; the most negative value maps to 2^23 (near-clip).
    always_comb begin
        mag = sample_q[SAMPLE_W-1] ? (~sample_q + SAMPLE_W'(1)) : sample_q;
    end

    // Next-state, sticky flags and AGC update.
    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        quiet_d       = quiet_q;
        sample_d      = sample_q;
        audio_d       = audio_q;
        audio_valid_d = 1'b0;
        mix_start_d   = 1'b0;
        shift_d       = shift_q;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;

        // Clear first so a coincident set below takes priority.
        if (overrun_clr_in) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end

        // A strobe while busy is dropped and flagged.
        if (sample_valid_in && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (!agc_en_in) begin
            quiet_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_valid_in) begin
                    state_d     = S_LAUNCH;
                    mix_start_d = 1'b1;
                    if (!agc_en_in) begin
                        shift_d = shift_manual_in;
                    end
                end
            end
            S_LAUNCH: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (mix_bus.mix_done_in) begin
                    sample_d = mix_bus.mixed_in;
                    state_d  = S_ADJUST;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_ADJUST: begin
                audio_d       = sample_q;
                audio_valid_d = 1'b1;
                state_d       = S_IDLE;
                // Shift only moves here so the mixer sees a stable value for the whole operation.
                if (agc_en_in) begin
                    if (mag >= CLIP_LIMIT) begin
                        quiet_d = '0;
                        if (shift_q != SHIFT_MAX) begin
                            shift_d = shift_q + SHIFT_W'(1);
                        end
                    end else if (mag < QUIET_LIMIT) begin
                        if (quiet_q == QC_W'(QUIET_HOLD - 1)) begin
                            quiet_d = '0;
                            if (shift_q != SHIFT_MIN) begin
                                shift_d = shift_q - SHIFT_W'(1);
                            end
                        end else begin
                            quiet_d = quiet_q + QC_W'(1);
                        end
                    end else begin
                        quiet_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            to_cnt_q      <= '0;
            quiet_q       <= '0;
            sample_q      <= '0;
            audio_q       <= '0;
            audio_valid_q <= 1'b0;
            mix_start_q   <= 1'b0;
            shift_q       <= INIT_SHIFT;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            quiet_q       <= quiet_d;
            sample_q      <= sample_d;
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
            mix_start_q   <= mix_start_d;
            shift_q       <= shift_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign mix_bus.mix_start_out = mix_start_q;
    assign mix_bus.shift_out     = shift_q;
    assign audio_out             = audio_q;
    assign audio_valid_out       = audio_valid_q;
    assign busy_out              = busy_q;
    assign overrun_out           = overrun_q;
    assign timeout_out           = timeout_q;
endmodule

// File: tb/tb_mix_controller.sv
// tb_mix_controller: directed vector table, hand-written corner sequences and a randomized
// run checked against a per-sample reference model of the shift/AGC rules.
module tb_mix_controller;
    localparam int QH = 4;

    logic               clk;
    logic               rst_n;
    logic               sample_valid;
    logic               agc_en;
    logic [4:0]         shift_manual;
    logic               overrun_clr;
    logic signed [23:0] audio;
    logic               audio_valid;
    logic               busy;
    logic               overrun;
    logic               timeout;

    mix_controller_if mix_bus();

    mix_controller #(
        .INIT_SHIFT (5'd8),
        .CLIP_LIMIT (24'h700000),
        .QUIET_LIMIT(24'h040000),
        .QUIET_HOLD (QH),
        .TIMEOUT    (255)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .sample_valid_in(sample_valid),
        .agc_en_in      (agc_en),
        .shift_manual_in(shift_manual),
        .overrun_clr_in (overrun_clr),
        .mix_bus        (mix_bus),
        .audio_out      (audio),
        .audio_valid_out(audio_valid),
        .busy_out       (busy),
        .overrun_out    (overrun),
        .timeout_out    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mixer model: answers each launch after mix_lat cycles, or never when mix_hang is set.
    int                 mix_lat  = 1;
    bit                 mix_hang = 1'b0;
    logic signed [23:0] mix_data = '0;
    int                 lat_cnt  = 0;
    bit                 pending  = 1'b0;

    always @(posedge clk) begin
        mix_bus.mix_done_in <= 1'b0;
        if (pending) begin
            if (lat_cnt <= 1) begin
                mix_bus.mix_done_in <= 1'b1;
                mix_bus.mixed_in    <= mix_data;
                pending             <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
        if (mix_bus.mix_start_out === 1'b1 && !mix_hang) begin
            pending <= 1'b1;
            lat_cnt <= mix_lat;
        end
    end

    int start_cnt = 0;
    int valid_cnt = 0;
    always @(negedge clk) begin
        if (mix_bus.mix_start_out === 1'b1) start_cnt <= start_cnt + 1;
        if (audio_valid === 1'b1)           valid_cnt <= valid_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state.
    int m_shift;
    int m_quiet;

    function automatic void ref_step(input logic signed [23:0] v, input bit agc, input int man);
        int s;
        int mag;
        s   = int'(v);
        mag = (s < 0) ? -s : s;
        if (!agc) begin
            m_shift = man;
            m_quiet = 0;
        end else if (mag >= 'h700000) begin
            m_shift = (m_shift < 31) ? m_shift + 1 : 31;
            m_quiet = 0;
        end else if (mag < 'h040000) begin
            m_quiet = m_quiet + 1;
            if (m_quiet == QH) begin
                m_quiet = 0;
                m_shift = (m_shift > 0) ? m_shift - 1 : 0;
            end
        end else begin
            m_quiet = 0;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full sample: strobe, launch, mixer completion, registered result.
    task automatic do_sample(input string tag, input logic signed [23:0] v, input int lat,
                             input bit agc, input logic [4:0] man, input logic [4:0] exp_shift);
        logic [4:0] s0;
        bit         moved;
        int         k_done;
        int         k_valid;
        @(negedge clk);
        agc_en       = agc;
        shift_manual = man;
        mix_data     = v;
        mix_lat      = lat;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check({tag, ".start"}, 32'(mix_bus.mix_start_out), 32'(1));
        s0      = mix_bus.shift_out;
        moved   = 1'b0;
        k_done  = -1;
        k_valid = -1;
        if (!agc) check({tag, ".manual_shift"}, 32'(s0), 32'(man));
        for (int k = 1; k <= 300 && k_valid < 0; k++) begin
            @(negedge clk);
            if (mix_bus.mix_done_in === 1'b1 && k_done < 0) k_done = k;
            if (audio_valid === 1'b1) k_valid = k;
            else if (mix_bus.shift_out !== s0) moved = 1'b1;
        end
        check({tag, ".valid_seen"}, 32'(k_valid > 0), 32'(1));
        if (k_valid > 0) begin
            check({tag, ".done_to_valid"}, 32'(k_valid - k_done), 32'(2));
            check({tag, ".audio"}, 32'(audio), 32'(v));
            check({tag, ".shift"}, 32'(mix_bus.shift_out), 32'(exp_shift));
            check({tag, ".shift_stable"}, 32'(moved), 32'(0));
            @(negedge clk);
            check({tag, ".valid_pulse"}, 32'(audio_valid), 32'(0));
            check({tag, ".idle"}, 32'(busy), 32'(0));
        end
    endtask

    typedef struct {
        bit                 rst;
        bit                 agc;
        logic [4:0]         man;
        logic signed [23:0] mixed;
        int                 lat;
        logic [4:0]         exp_shift;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit a, logic [4:0] m, logic [23:0] x, int l, logic [4:0] s);
        vec_t e;
        e.rst = r; e.agc = a; e.man = m; e.mixed = x; e.lat = l; e.exp_shift = s;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                 base_s;
        int                 base_v;
        int                 first;
        bit                 saw_done;
        logic signed [23:0] prev;
        logic signed [23:0] v;
        int                 vi;
        int                 lat;
        bit                 agc;
        logic [4:0]         man;
        logic [23:0]        bnd [8];

        rst_n        = 1'b0;
        sample_valid = 1'b0;
        agc_en       = 1'b0;
        shift_manual = 5'd0;
        overrun_clr  = 1'b0;

        // Manual, clip growth, clip boundaries, manual-to-AGC handover.
        tbl.push_back(mk(1, 0, 5'd3,  24'h001234, 34, 5'd3));
        tbl.push_back(mk(1, 1, 5'd20, 24'h7FFFFF, 3, 5'd9));
        tbl.push_back(mk(0, 1, 5'd20, 24'h7FFFFF, 4, 5'd10));
        tbl.push_back(mk(0, 1, 5'd20, 24'h7FFFFF, 5, 5'd11));
        tbl.push_back(mk(0, 1, 5'd20, 24'h800000, 2, 5'd12));
        tbl.push_back(mk(0, 1, 5'd20, 24'h900000, 3, 5'd13));
        tbl.push_back(mk(0, 1, 5'd20, 24'h700000, 1, 5'd14));
        tbl.push_back(mk(0, 1, 5'd20, 24'h6FFFFF, 3, 5'd14));
        tbl.push_back(mk(0, 0, 5'd5,  24'h7FFFFF, 3, 5'd5));
        tbl.push_back(mk(0, 1, 5'd20, 24'h7FFFFF, 3, 5'd6));
        // Nine quiet samples: decrements after the 4th and 8th.
        tbl.push_back(mk(1, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd7));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd7));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd7));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd7));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd6));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd6));
        // A mid-level sample restarts the quiet run.
        tbl.push_back(mk(1, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h100000, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 3, 5'd7));
        // Quiet threshold edges, both signs.
        tbl.push_back(mk(1, 1, 5'd0, 24'h03FFFF, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'hFC0001, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h040000, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'hFFFFF0, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000000, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000001, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h03FFFF, 2, 5'd7));
        // Disabling AGC zeroes the quiet run.
        tbl.push_back(mk(1, 1, 5'd0, 24'h000010, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 2, 5'd8));
        tbl.push_back(mk(0, 0, 5'd8, 24'h000010, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 2, 5'd8));
        tbl.push_back(mk(0, 1, 5'd0, 24'h000010, 2, 5'd7));

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst.shift",    32'(mix_bus.shift_out),     32'(8));
        check("rst.start",    32'(mix_bus.mix_start_out), 32'(0));
        check("rst.audio",    32'(audio),                 32'(0));
        check("rst.valid",    32'(audio_valid),           32'(0));
        check("rst.busy",     32'(busy),                  32'(0));
        check("rst.overrun",  32'(overrun),               32'(0));
        check("rst.timeout",  32'(timeout),               32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            do_sample($sformatf("vec%0d", i), tbl[i].mixed, tbl[i].lat, tbl[i].agc,
                      tbl[i].man, tbl[i].exp_shift);
        end

        // Thirty near-clip samples of alternating sign saturate the shift at 31.
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            vi = int'($urandom_range(32'h700000, 32'h7FFFFF));
            if (i % 2 == 0) vi = -vi;
            do_sample($sformatf("clip%0d", i), 24'(vi), 2, 1'b1, 5'd0,
                      5'((8 + i > 31) ? 31 : 8 + i));
        end

        // Long quiet run saturates the shift at 0.
        do_reset();
        for (int i = 1; i <= 36; i++) begin
            vi = int'($urandom_range(0, 32'h03FFFF));
            if ($urandom_range(0, 1) == 1) vi = -vi;
            do_sample($sformatf("quiet%0d", i), 24'(vi), 1, 1'b1, 5'd0,
                      5'((8 - i / QH < 0) ? 0 : 8 - i / QH));
        end

        // Overrun: second strobe while waiting is dropped; set beats a coincident clear.
        do_reset();
        @(negedge clk);
        agc_en = 1'b0; shift_manual = 5'd3; mix_data = 24'sh00ABCD; mix_lat = 34;
        sample_valid = 1'b1;
        base_s = start_cnt;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("ovr.set", 32'(overrun), 32'(1));
        @(negedge clk);
        sample_valid = 1'b1; overrun_clr = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; overrun_clr = 1'b0;
        check("ovr.set_wins", 32'(overrun), 32'(1));
        first = -1;
        for (int k = 1; k <= 100 && first < 0; k++) begin
            @(negedge clk);
            if (audio_valid === 1'b1) first = k;
        end
        check("ovr.valid_seen", 32'(first > 0), 32'(1));
        check("ovr.audio", 32'(audio), 32'(24'sh00ABCD));
        repeat (3) @(negedge clk);
        check("ovr.one_launch", 32'(start_cnt - base_s), 32'(1));
        check("ovr.sticky", 32'(overrun), 32'(1));
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr.clear", 32'(overrun), 32'(0));

        // Timeout: mixer never completes; abort after 255 cycles of waiting.
        prev   = audio;
        base_v = valid_cnt;
        @(negedge clk);
        mix_hang = 1'b1; agc_en = 1'b0; shift_manual = 5'd3; sample_valid = 1'b1;
        first = -1;
        for (int k = 1; k <= 400 && first < 0; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (k == 256) begin
                check("to.busy_before", 32'(busy), 32'(1));
                check("to.not_yet", 32'(timeout), 32'(0));
            end
            if (timeout === 1'b1) first = k;
        end
        check("to.latency", 32'(first), 32'(257));
        check("to.idle", 32'(busy), 32'(0));
        check("to.audio_kept", 32'(audio), 32'(prev));
        @(negedge clk);
        check("to.no_valid", 32'(valid_cnt - base_v), 32'(0));
        mix_hang = 1'b0;
        do_sample("to.recover", 24'sh055555, 5, 1'b0, 5'd3, 5'd3);
        check("to.sticky", 32'(timeout), 32'(1));
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("to.clear", 32'(timeout), 32'(0));

        // Reset while waiting; the late mixer completion must be ignored.
        @(negedge clk);
        agc_en = 1'b0; shift_manual = 5'd3; mix_data = 24'sh0BEEF0; mix_lat = 34;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rmid.busy_before", 32'(busy), 32'(1));
        check("rmid.shift_before", 32'(mix_bus.shift_out), 32'(3));
        rst_n = 1'b0;
        #1;
        check("rmid.shift", 32'(mix_bus.shift_out), 32'(8));
        check("rmid.audio", 32'(audio), 32'(0));
        check("rmid.busy",  32'(busy), 32'(0));
        check("rmid.valid", 32'(audio_valid), 32'(0));
        check("rmid.start", 32'(mix_bus.mix_start_out), 32'(0));
        base_v   = valid_cnt;
        base_s   = start_cnt;
        saw_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mix_bus.mix_done_in === 1'b1) saw_done = 1'b1;
        end
        check("rmid.late_done", 32'(saw_done), 32'(1));
        check("rmid.no_valid", 32'(valid_cnt - base_v), 32'(0));
        check("rmid.no_start", 32'(start_cnt - base_s), 32'(0));
        check("rmid.shift_after", 32'(mix_bus.shift_out), 32'(8));
        check("rmid.audio_after", 32'(audio), 32'(0));

        // Randomized samples against the reference model.
        bnd[0] = 24'h700000; bnd[1] = 24'h6FFFFF; bnd[2] = 24'h040000; bnd[3] = 24'h03FFFF;
        bnd[4] = 24'h800000; bnd[5] = 24'hFC0000; bnd[6] = 24'hFC0001; bnd[7] = 24'h900000;
        do_reset();
        m_shift = 8;
        m_quiet = 0;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: v = 24'($urandom);
                1, 4, 5: begin
                    vi = int'($urandom_range(0, 32'h03FFFF));
                    if ($urandom_range(0, 1) == 1) vi = -vi;
                    v = 24'(vi);
                end
                2: v = bnd[$urandom_range(0, 7)];
                default: begin
                    vi = int'($urandom_range(32'h700000, 32'h800000));
                    if ($urandom_range(0, 1) == 1) vi = -vi;
                    v = 24'(vi);
                end
            endcase
            agc = ($urandom_range(0, 4) != 0);
            man = 5'($urandom_range(0, 31));
            lat = int'($urandom_range(1, 40));
            ref_step(v, agc, int'(man));
            do_sample($sformatf("rnd%0d", n), v, lat, agc, man, 5'(m_shift));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
